// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data memory with a valid/ready request port,
// configurable wait states, an address-error response and a test_value tap.
// Optional feature macro: DMEM_BYTE_EN (req_be gates individual byte lanes
// on stores). Without it every store writes the full word.
module data_mem_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned TEST_ADDR   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [15:0]           test_value
);

  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned OFF_W     = $clog2(BE_W);
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned TEST_WORD = TEST_ADDR / BE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_write;
  logic [DATA_W-1:0]   lat_wdata;
  logic [BE_W-1:0]     lat_be;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept_c;
  logic                commit_c;
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_write;
  logic [DATA_W-1:0]   cur_wdata;
  logic [BE_W-1:0]     cur_be;
  logic [ADDR_W-1:0]   word_c;
  logic                misalign_c;
  logic                range_err_c;
  logic                err_c;
  logic [IDX_W-1:0]    idx_c;

  // Handshake: a request is taken only in IDLE once ready has come up
  assign accept_c = (state == IDLE) && req_ready && req_valid;

  // Commit happens on the edge entering RESP; with zero wait states that is the accept edge
  assign commit_c = ((WAIT_STATES == 0) && accept_c) ||
                    ((state == WAIT) && (wait_cnt == CNT_W'(1)));

  // With zero wait states the request has not been latched yet at commit, so use the port
  always_comb begin
    cur_addr  = lat_addr;
    cur_write = lat_write;
    cur_wdata = lat_wdata;
    cur_be    = lat_be;
    if (WAIT_STATES == 0) begin
      cur_addr  = req_addr;
      cur_write = req_write;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
  end

  // Address decode: word index, misalignment and range check
  assign word_c      = cur_addr >> OFF_W;
  assign misalign_c  = (cur_addr & ADDR_W'(BE_W - 1)) != '0;
  assign range_err_c = word_c >= ADDR_W'(DEPTH);
  assign err_c       = misalign_c || range_err_c;
  assign idx_c       = word_c[IDX_W-1:0];

  // Observation tap, combinational so a store to TEST_ADDR shows in its RESP cycle
  assign test_value = mem[IDX_W'(TEST_WORD)][15:0];

  // Request FSM with registered handshake and response outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept_c) begin
            req_ready <= 1'b0;
            lat_addr  <= req_addr;
            lat_write <= req_write;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            wait_cnt  <= CNT_W'(WAIT_STATES);
            state     <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          req_ready <= 1'b0;
          wait_cnt  <= wait_cnt - CNT_W'(1);
          if (wait_cnt == CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase

      if (commit_c) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err_c;
        rsp_rdata <= (!cur_write && !err_c) ? mem[idx_c] : '0;
      end
    end
  end

  // Storage array: cleared on reset, updated only by a committed error-free store
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit_c && cur_write && !err_c) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
`ifdef DMEM_BYTE_EN
        if (cur_be[b]) begin
          mem[idx_c][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
`else
        mem[idx_c][8*b +: 8] <= cur_wdata[8*b +: 8];
`endif
      end
    end
  end

`ifndef DMEM_BYTE_EN
  // Byte enables carry no meaning in full-word builds
  logic unused_be;
  assign unused_be = ^cur_be;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: one instance with two wait states and one with none,
// sharing request fields; expected responses are queued when a request is
// issued and compared when the response strobe appears.
module tb_data_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be    = '0;

  logic        a_valid = 1'b0;
  logic        a_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic [15:0] a_test_value;

  logic        z_valid = 1'b0;
  logic        z_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;
  logic [15:0] z_test_value;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  data_mem_ctrl #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_STATES(2), .TEST_ADDR(0)
  ) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(a_valid), .req_ready(a_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .test_value(a_test_value)
  );

  data_mem_ctrl #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_STATES(0), .TEST_ADDR(0)
  ) u_dut0 (
    .clock(clock), .reset(reset),
    .req_valid(z_valid), .req_ready(z_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
    .test_value(z_test_value)
  );

  // Issue one request (called at a negedge), then check latency, payload and strobe width
  task automatic do_req(input bit zw, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input bit exp_err,
                        output int acc_cyc);
    int   n;
    int   lat;
    int   exp_lat;
    bit   got;
    rsp_t e;
    rsp_t act;
    exp_lat = zw ? 1 : 3;
    sb.push_back(rsp_t'{rdata: exp_rdata, err: exp_err});
    n = 0;
    while (!(zw ? z_ready : a_ready) && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if ((zw ? z_ready : a_ready) !== 1'b1) begin
      $display("FAIL ready_wait addr=%h: req_ready=%b, required 1", addr, zw ? z_ready : a_ready);
      errors++;
    end
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    if (zw) z_valid = 1'b1;
    else    a_valid = 1'b1;
    acc_cyc = cyc;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clock);
      lat++;
      a_valid = 1'b0;
      z_valid = 1'b0;
      got = zw ? z_rsp_valid : a_rsp_valid;
    end
    checks++;
    if (!got) begin
      $display("FAIL rsp_timeout addr=%h: no rsp_valid within %0d cycles", addr, lat);
      errors++;
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    checks++;
    if (lat !== exp_lat) begin
      $display("FAIL latency addr=%h: %0d cycles, required %0d", addr, lat, exp_lat);
      errors++;
    end
    act.rdata = zw ? z_rsp_rdata : a_rsp_rdata;
    act.err   = zw ? z_rsp_err : a_rsp_err;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard addr=%h: response with empty queue", addr);
      errors++;
    end else begin
      e = sb.pop_front();
      if (act.rdata !== e.rdata) begin
        $display("FAIL rsp_rdata addr=%h: got %h, required %h", addr, act.rdata, e.rdata);
        errors++;
      end
      checks++;
      if (act.err !== e.err) begin
        $display("FAIL rsp_err addr=%h: got %b, required %b", addr, act.err, e.err);
        errors++;
      end
    end
    @(negedge clock);
    checks++;
    if ((zw ? z_rsp_valid : a_rsp_valid) !== 1'b0) begin
      $display("FAIL rsp_one_cycle addr=%h: rsp_valid=%b after strobe, required 0", addr,
               zw ? z_rsp_valid : a_rsp_valid);
      errors++;
    end
  endtask

  task automatic test_reset();
    int  t;
    bit  seen;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (a_ready !== 1'b0 || z_ready !== 1'b0) begin
      $display("FAIL reset_ready: got %b/%b, required 0/0", a_ready, z_ready);
      errors++;
    end
    checks++;
    if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 32'h0) begin
      $display("FAIL reset_rsp: valid=%b err=%b rdata=%h, required 0/0/0", a_rsp_valid, a_rsp_err, a_rsp_rdata);
      errors++;
    end
    checks++;
    if (a_test_value !== 16'h0 || z_test_value !== 16'h0) begin
      $display("FAIL reset_test_value: got %h/%h, required 0000", a_test_value, z_test_value);
      errors++;
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (a_ready !== 1'b1) begin
      $display("FAIL ready_after_release: got %b, required 1", a_ready);
      errors++;
    end
    // Store to 0x4, then reset while it sits in WAIT
    req_write = 1'b1;
    req_addr  = 32'h4;
    req_wdata = 32'hCAFEF00D;
    req_be    = 4'hF;
    a_valid   = 1'b1;
    @(negedge clock);
    a_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clock);
    checks++;
    if (a_ready !== 1'b0 || a_rsp_valid !== 1'b0) begin
      $display("FAIL midop_reset: ready=%b rsp_valid=%b, required 0/0", a_ready, a_rsp_valid);
      errors++;
    end
    reset = 1'b0;
    seen = 1'b0;
    for (t = 0; t < 6; t++) begin
      @(negedge clock);
      if (a_rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      $display("FAIL dropped_response: rsp_valid seen after reset release, required none");
      errors++;
    end
    checks++;
    if (a_ready !== 1'b1) begin
      $display("FAIL ready_after_midop: got %b, required 1", a_ready);
      errors++;
    end
    do_req(1'b0, 1'b0, 32'h4, 32'h0, 4'hF, 32'h0, 1'b0, t);
  endtask

  task automatic test_latency();
    int t;
    do_req(1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, t);
    checks++;
    if (a_test_value !== 16'hBEEF) begin
      $display("FAIL test_value_store: got %h, required beef", a_test_value);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, t0);
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, t1);
    checks++;
    if (t1 - t0 !== 4) begin
      $display("FAIL throughput: accepts %0d cycles apart, required 4", t1 - t0);
      errors++;
    end
  endtask

  task automatic test_byte_lanes();
    int          t;
    logic [31:0] exp_w;
`ifdef DMEM_BYTE_EN
    exp_w = 32'hDEAD33EF;
`else
    exp_w = 32'h11223344;
`endif
    do_req(1'b0, 1'b1, 32'h0, 32'h11223344, 4'h2, 32'h0, 1'b0, t);
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, exp_w, 1'b0, t);
    checks++;
    if (a_test_value !== exp_w[15:0]) begin
      $display("FAIL test_value_lanes: got %h, required %h", a_test_value, exp_w[15:0]);
      errors++;
    end
  endtask

  task automatic test_errors();
    int          t;
    logic [31:0] exp_w;
`ifdef DMEM_BYTE_EN
    exp_w = 32'hDEAD33EF;
`else
    exp_w = 32'h11223344;
`endif
    do_req(1'b0, 1'b0, 32'h2,   32'h0,        4'hF, 32'h0, 1'b1, t);
    do_req(1'b0, 1'b0, 32'h100, 32'h0,        4'hF, 32'h0, 1'b1, t);
    do_req(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, t);
    do_req(1'b0, 1'b1, 32'h1,   32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, t);
    do_req(1'b0, 1'b0, 32'h0,   32'h0,        4'hF, exp_w, 1'b0, t);
    checks++;
    if (a_test_value !== exp_w[15:0]) begin
      $display("FAIL test_value_errors: got %h, required %h", a_test_value, exp_w[15:0]);
      errors++;
    end
  endtask

  task automatic test_zero_wait();
    int          t;
    logic [31:0] exp_be0;
`ifdef DMEM_BYTE_EN
    exp_be0 = 32'h0;
`else
    exp_be0 = 32'h77;
`endif
    do_req(1'b1, 1'b1, 32'hFC, 32'h5A, 4'hF, 32'h0,  1'b0, t);
    do_req(1'b1, 1'b0, 32'hFC, 32'h0,  4'hF, 32'h5A, 1'b0, t);
    do_req(1'b1, 1'b1, 32'hF8, 32'h77, 4'h0, 32'h0,  1'b0, t);
    do_req(1'b1, 1'b0, 32'hF8, 32'h0,  4'hF, exp_be0, 1'b0, t);
    do_req(1'b1, 1'b0, 32'hFD, 32'h0,  4'hF, 32'h0,  1'b1, t);
    checks++;
    if (z_test_value !== 16'h0) begin
      $display("FAIL test_value_zero_wait: got %h, required 0000", z_test_value);
      errors++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_latency();
    test_back_to_back();
    test_byte_lanes();
    test_errors();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
